// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and constants for the RV32M iterative
//                multiply/divide sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    // funct3 encoding of the M-extension operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_t;

    // Architectural constants for the 32-bit configuration
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : Single iteration of the multiply/divide datapath.
//                Multiply: {hi,lo} is the product register with the
//                multiplier in lo; add the multiplicand into hi when lo[0]
//                is set, then shift the whole register right by one.
//                Divide: hi is the partial remainder, lo the dividend being
//                shifted out / quotient being shifted in; restoring step.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_is_div,
    input  logic [DATA_WIDTH-1:0] i_hi,
    input  logic [DATA_WIDTH-1:0] i_lo,
    input  logic [DATA_WIDTH-1:0] i_operand,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    logic [DATA_WIDTH:0] w_sum;
    logic [DATA_WIDTH:0] w_shift;
    logic                w_fits;

    // One shift-add or restoring-subtract iteration; the trial difference
    // is taken at DATA_WIDTH bits because it is only used when it fits.
    always_comb begin
        w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : '0);
        w_shift = {i_hi, i_lo[DATA_WIDTH-1]};
        w_fits  = (w_shift >= {1'b0, i_operand});
        if (i_is_div) begin
            o_hi = w_fits ? (w_shift[DATA_WIDTH-1:0] - i_operand) : w_shift[DATA_WIDTH-1:0];
            o_lo = {i_lo[DATA_WIDTH-2:0], w_fits};
        end else begin
            o_hi = w_sum[DATA_WIDTH:1];
            o_lo = {w_sum[0], i_lo[DATA_WIDTH-1:1]};
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative RV32M multiply/divide sequencer for the execute
//                stage. Latches operand magnitudes, runs DATA_WIDTH
//                shift-add or restoring-divide steps while stalling the
//                pipeline, then applies the sign fix-up and pulses DoneE.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StartE,
    input  logic [2:0]            MulDivOpE,
    input  logic [DATA_WIDTH-1:0] SrcAE,
    input  logic [DATA_WIDTH-1:0] SrcBE,
    input  logic                  FlushE,
    output logic                  StallMD,
    output logic                  DoneE,
    output logic [DATA_WIDTH-1:0] ResultMD
);

    localparam logic [DATA_WIDTH-1:0] c_all_ones  = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] c_int_min   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  c_last_step = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0]  c_cnt_max   = CNT_WIDTH'(DATA_WIDTH);

    muldiv_state_t           r_state;
    muldiv_state_t           w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;
    logic [DATA_WIDTH-1:0]   r_operand;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [2:0]              r_op;
    logic                    r_neg;
    logic [DATA_WIDTH-1:0]   r_result;

    muldiv_op_t              w_op;
    logic                    w_a_signed;
    logic                    w_b_signed;
    logic                    w_a_neg;
    logic                    w_b_neg;
    logic                    w_is_div;
    logic [DATA_WIDTH-1:0]   w_abs_a;
    logic [DATA_WIDTH-1:0]   w_abs_b;
    logic                    w_b_zero;
    logic                    w_overflow;
    logic                    w_special;
    logic [DATA_WIDTH-1:0]   w_special_res;
    logic                    w_neg_flag;
    logic                    w_start;
    logic                    w_busy;
    logic                    w_last;
    logic [DATA_WIDTH-1:0]   w_step_hi;
    logic [DATA_WIDTH-1:0]   w_step_lo;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
    logic [DATA_WIDTH-1:0]   w_mul_res;
    logic [DATA_WIDTH-1:0]   w_div_raw;
    logic [DATA_WIDTH-1:0]   w_div_res;
    logic [DATA_WIDTH-1:0]   w_final;

    // Operand decode: signedness, magnitudes, and the divide special cases
    always_comb begin
        w_op       = muldiv_op_t'(MulDivOpE);
        w_is_div   = MulDivOpE[2];
        w_a_signed = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                     (w_op == OP_DIV) || (w_op == OP_REM);
        w_b_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
        w_a_neg    = w_a_signed & SrcAE[DATA_WIDTH-1];
        w_b_neg    = w_b_signed & SrcBE[DATA_WIDTH-1];
        w_abs_a    = w_a_neg ? -SrcAE : SrcAE;
        w_abs_b    = w_b_neg ? -SrcBE : SrcBE;
        w_b_zero   = (SrcBE == '0);
        w_overflow = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                     (SrcAE == c_int_min) && (SrcBE == c_all_ones);
        w_special  = w_is_div & (w_b_zero | w_overflow);
        // funct3[1] distinguishes remainder from quotient in the divide group
        if (w_b_zero) begin
            w_special_res = MulDivOpE[1] ? SrcAE : c_all_ones;
        end else begin
            w_special_res = MulDivOpE[1] ? '0 : c_int_min;
        end
        // Remainder follows the dividend; everything else follows the XOR
        w_neg_flag = (w_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_start    = (r_state == S_IDLE) & StartE & ~FlushE;
    end

    assign w_busy = (r_state == S_MUL) || (r_state == S_DIV);
    assign w_last = w_busy && (r_cnt == c_last_step);

    muldiv_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .i_is_div  (r_state == S_DIV),
        .i_hi      (r_hi),
        .i_lo      (r_lo),
        .i_operand (r_operand),
        .o_hi      (w_step_hi),
        .o_lo      (w_step_lo)
    );

    // Sign fix-up and result selection applied to the final step's output
    always_comb begin
        w_prod     = {w_step_hi, w_step_lo};
        w_prod_fix = r_neg ? -w_prod : w_prod;
        w_mul_res  = (r_op == OP_MUL) ? w_prod_fix[DATA_WIDTH-1:0]
                                      : w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
        w_div_raw  = r_op[1] ? w_step_hi : w_step_lo;
        w_div_res  = r_neg ? -w_div_raw : w_div_raw;
        w_final    = (r_state == S_DIV) ? w_div_res : w_mul_res;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, stall request and completion pulse
    always_comb begin
        w_state_nxt = r_state;
        StallMD     = 1'b0;
        DoneE       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_special) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = w_is_div ? S_DIV : S_MUL;
                        StallMD     = 1'b1;
                    end
                end
            end
            S_MUL, S_DIV: begin
                StallMD = 1'b1;
                if (FlushE) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                DoneE       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration, saturating counter and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_operand <= '0;
            r_cnt     <= '0;
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_result  <= '0;
        end else if (w_start) begin
            r_hi      <= '0;
            r_lo      <= w_abs_a;
            r_operand <= w_abs_b;
            r_cnt     <= '0;
            r_op      <= MulDivOpE;
            r_neg     <= w_neg_flag;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (w_busy && !FlushE) begin
            r_hi <= w_step_hi;
            r_lo <= w_step_lo;
            if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            if (w_last) begin
                r_result <= w_final;
            end
        end
    end

    assign ResultMD = r_result;

endmodule : muldiv_seq
`default_nettype wire
